// File: rtl/hilo_div_unit.sv
// HI/LO register pair with a 32-cycle restoring divider (DIV/DIVU), fed by the EX-stage ALU.
// state | meaning:  S_IDLE = single-cycle ops / accept divide,  S_ITER = one quotient bit per cycle,  S_FIX = apply signs, write HI/LO
module hilo_div_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] AluHi,
    input  logic [31:0] AluLo,
    output logic [31:0] Hi_out,
    output logic [31:0] Lo_out,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI  = 3'd0;
    localparam logic [2:0] OP_MTLO  = 3'd1;
    localparam logic [2:0] OP_WPAIR = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] dvd_q, dvd_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic [32:0] rem_sh;
    logic [31:0] quo_sh;
    logic [32:0] diff;
    logic        is_signed;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        dvd_d     = dvd_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        is_signed = (Op == OP_DIV);

        // Shifted partial remainder can reach 33 bits; diff[32] is the borrow.
        rem_sh = {rem_q, quo_q[31]};
        quo_sh = {quo_q[30:0], 1'b0};
        diff   = rem_sh - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MTHI:  hi_d = A;
                        OP_MTLO:  lo_d = A;
                        OP_WPAIR: begin
                            hi_d = AluHi;
                            lo_d = AluLo;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_ITER;
                            cnt_d   = 5'd0;
                            rem_d   = 32'd0;
                            quo_d   = (is_signed && A[31]) ? -A : A;
                            dvs_d   = (is_signed && B[31]) ? -B : B;
                            dvd_d   = A;
                            qneg_d  = is_signed && (A[31] ^ B[31]);
                            rneg_d  = is_signed && A[31];
                        end
                        default: ;
                    endcase
                end
            end
            S_ITER: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = quo_sh | 32'd1;
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = quo_sh;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Divide-by-zero bypasses sign fix-up so Hi returns the raw dividend.
                if (dvs_q == 32'd0) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = dvd_q;
                end else begin
                    lo_d = qneg_q ? -quo_q : quo_q;
                    hi_d = rneg_q ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            dvd_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign Hi_out = hi_q;
    assign Lo_out = lo_q;
    assign Busy   = (state_q != S_IDLE);
    assign Done   = done_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed cases from the plan plus randomized
// commands checked against an arithmetic reference model.
module tb_hilo_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    hilo_div_unit dut (
        .Clk    (clk),
        .Reset  (reset),
        .Start  (start),
        .Op     (op),
        .A      (a),
        .B      (b),
        .AluHi  (alu_hi),
        .AluLo  (alu_lo),
        .Hi_out (hi_out),
        .Lo_out (lo_out),
        .Busy   (busy),
        .Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MIPS semantics: truncating quotient, remainder carries the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [2:0] f_op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (f_op == 3'd3) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_single(input logic [2:0] t_op, input logic [31:0] t_a,
                             input logic [31:0] t_hi, input logic [31:0] t_lo);
        start = 1'b1; op = t_op; a = t_a; alu_hi = t_hi; alu_lo = t_lo;
        tick();
        start = 1'b0;
        case (t_op)
            3'd0: mdl_hi = t_a;
            3'd1: mdl_lo = t_a;
            3'd2: begin mdl_hi = t_hi; mdl_lo = t_lo; end
            default: ;
        endcase
        check_val("single_hi", hi_out, mdl_hi);
        check_val("single_lo", lo_out, mdl_lo);
        check_val("single_busy", {31'd0, busy}, 32'd0);
    endtask

    // Returns at the Done cycle so a following divide can be issued back-to-back.
    task automatic do_div(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input bit inject);
        logic [63:0] exp;
        int cyc;
        exp = ref_div(t_op, t_a, t_b);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            check_val("iter_hi_stable", hi_out, mdl_hi);
            check_val("iter_lo_stable", lo_out, mdl_lo);
            if (inject && cyc == 10) begin
                start = 1'b1; op = 3'd0; a = 32'hAA;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        mdl_hi = exp[63:32];
        mdl_lo = exp[31:0];
        check_val("busy_cycles", cyc, 33);
        check_val("done_rise", {31'd0, done}, 32'd1);
        check_val("div_hi", hi_out, mdl_hi);
        check_val("div_lo", lo_out, mdl_lo);
    endtask

    task automatic done_fall();
        tick();
        check_val("done_fall", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int pulses;
        logic [31:0] rb;
        logic [2:0]  rop;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        alu_hi = 32'd0; alu_lo = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_hi", hi_out, 32'd0);
        check_val("rst_lo", lo_out, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);

        do_single(3'd0, 32'd6, 32'd0, 32'd0);
        do_single(3'd1, 32'd5, 32'd0, 32'd0);
        do_single(3'd2, 32'd0, 32'h1, 32'hFFFF_FFF0);
        do_single(3'd6, 32'h1234, 32'h55, 32'h66);

        do_div(3'd4, 32'd100, 32'd7, 1'b0);             done_fall();
        do_div(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);       done_fall();
        do_div(3'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);       done_fall();
        do_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); done_fall();
        do_div(3'd4, 32'h10, 32'd0, 1'b0);              done_fall();
        do_div(3'd3, 32'hFFFF_FFF0, 32'd0, 1'b0);       done_fall();
        do_div(3'd3, 32'd0, 32'd9, 1'b0);               done_fall();
        do_div(3'd4, 32'd100, 32'd7, 1'b1);             done_fall();

        // Back-to-back: second divide issued in the Done cycle of the first.
        do_div(3'd4, 32'd100, 32'd7, 1'b0);
        do_div(3'd4, 32'd9, 32'd4, 1'b0);
        done_fall();

        // Reset mid-divide.
        start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_hi = 32'd0; mdl_lo = 32'd0;
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_done", {31'd0, done}, 32'd0);
        check_val("midrst_hi", hi_out, 32'd0);
        check_val("midrst_lo", lo_out, 32'd0);
        pulses = 0;
        repeat (40) begin
            tick();
            if (done) pulses++;
        end
        check_val("midrst_no_done", pulses, 0);

        // Reset overrides a same-cycle Start.
        do_single(3'd0, 32'h77, 32'd0, 32'd0);
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'd50; b = 32'd5;
        tick();
        reset = 1'b0; start = 1'b0;
        mdl_hi = 32'd0; mdl_lo = 32'd0;
        check_val("rst_over_hi", hi_out, 32'd0);
        check_val("rst_over_busy", {31'd0, busy}, 32'd0);

        // Randomized command mix.
        repeat (30) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if (rop == 3'd3 || rop == 3'd4) begin
                do_div(rop, $urandom, rb, 1'b0);
                done_fall();
            end else begin
                do_single(rop, $urandom, $urandom, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
